// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution path: datapath width, the
// default performance counter width and the prediction bundle that travels
// from the predictor in F through the D and E pipeline registers.
package branch_resolve_pkg;

  localparam int XLEN          = 32;
  localparam int CNT_WIDTH_DEF = 16;

  // Prediction bundle shared with the predictor and the hazard unit.
  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } pred_t;

  // A flushed pipeline slot: predicted not-taken, so it never redirects.
  localparam pred_t PRED_BUBBLE = '0;

endpackage

// File: rtl/branch_resolve_sat_counter.sv
// Saturating up-counter used for performance visibility. It sticks at
// all-ones instead of wrapping, and a clear beats a simultaneous increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Reset/clear to zero, otherwise count up until all-ones is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution. The F-stage prediction rides through the
// D and E registers; in E it is compared with the real outcome to produce a
// redirect, the corrected fetch address and the predictor training enables.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PrPCSrc_F,
  input  logic [XLEN-1:0]      PrALUResult_F,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 Branch_E,
  input  logic                 PCSrc_E,
  input  logic [XLEN-1:0]      ALUResult_E,
  input  logic [XLEN-1:0]      PC_plus4_E,
  input  logic                 CntClr,
  output logic                 PrPCSrc_E,
  output logic [XLEN-1:0]      PrALUResult_E,
  output logic                 Mispredict_E,
  output logic [XLEN-1:0]      PC_Redirect,
  output logic                 WE_PrPCSrc,
  output logic                 WE_PrALUResult,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MissCount
);

  pred_t pred_d;
  pred_t pred_e;
  logic  act;
  logic  actual_taken;
  logic  dir_miss;
  logic  tgt_miss;
  logic  alias_miss;

  // D register: a mispredict flush outranks a stall so the wrong-path entry never survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_d <= PRED_BUBBLE;
    end else if (FlushD || Mispredict_E) begin
      pred_d <= PRED_BUBBLE;
    end else if (!StallD) begin
      pred_d <= '{taken: PrPCSrc_F, target: PrALUResult_F};
    end
  end

  // E register: an external flush and a mispredict collapse into one clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_e <= PRED_BUBBLE;
    end else if (FlushE || Mispredict_E) begin
      pred_e <= PRED_BUBBLE;
    end else if (!StallE) begin
      pred_e <= pred_d;
    end
  end

  assign PrPCSrc_E     = pred_e.taken;
  assign PrALUResult_E = pred_e.target;

  // Resolution only acts while E is moving, so a stalled branch resolves exactly once on release.
  always_comb begin
    act            = !StallE;
    actual_taken   = Branch_E && PCSrc_E;
    dir_miss       = Branch_E && (pred_e.taken != PCSrc_E);
    tgt_miss       = actual_taken && pred_e.taken && (pred_e.target != ALUResult_E);
    alias_miss     = !Branch_E && pred_e.taken;
    Mispredict_E   = act && (dir_miss || tgt_miss || alias_miss);
    PC_Redirect    = actual_taken ? ALUResult_E : PC_plus4_E;
    WE_PrPCSrc     = act && (dir_miss || alias_miss);
    WE_PrALUResult = act && actual_taken && (!pred_e.taken || tgt_miss);
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (act && Branch_E),
    .count (BranchCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (Mispredict_E),
    .count (MissCount)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by a
// randomized run, all compared against a behavioural next-PC model.
module tb_branch_resolve;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          PrPCSrc_F;
  logic [31:0]   PrALUResult_F;
  logic          StallD, FlushD, StallE, FlushE;
  logic          Branch_E, PCSrc_E;
  logic [31:0]   ALUResult_E, PC_plus4_E;
  logic          CntClr;
  logic          PrPCSrc_E;
  logic [31:0]   PrALUResult_E;
  logic          Mispredict_E;
  logic [31:0]   PC_Redirect;
  logic          WE_PrPCSrc, WE_PrALUResult;
  logic [CW-1:0] BranchCount, MissCount;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: the prediction sitting in each stage plus the counter values.
  logic        m_d_taken, m_e_taken;
  logic [31:0] m_d_tgt, m_e_tgt;
  int          m_bc, m_mc;

  // Expected combinational outputs for the current inputs.
  logic        exp_mis, exp_we_dir, exp_we_tgt;
  logic [31:0] exp_redirect;

  branch_resolve #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .PrPCSrc_F      (PrPCSrc_F),
    .PrALUResult_F  (PrALUResult_F),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .StallE         (StallE),
    .FlushE         (FlushE),
    .Branch_E       (Branch_E),
    .PCSrc_E        (PCSrc_E),
    .ALUResult_E    (ALUResult_E),
    .PC_plus4_E     (PC_plus4_E),
    .CntClr         (CntClr),
    .PrPCSrc_E      (PrPCSrc_E),
    .PrALUResult_E  (PrALUResult_E),
    .Mispredict_E   (Mispredict_E),
    .PC_Redirect    (PC_Redirect),
    .WE_PrPCSrc     (WE_PrPCSrc),
    .WE_PrALUResult (WE_PrALUResult),
    .BranchCount    (BranchCount),
    .MissCount      (MissCount)
  );

  always #5 clk = ~clk;

  // The prediction is right when its direction equals the real control flow
  // and, if both say taken, the targets agree.
  task automatic model_eval();
    logic act, real_taken;
    act          = !StallE;
    real_taken   = Branch_E && PCSrc_E;
    exp_redirect = real_taken ? ALUResult_E : PC_plus4_E;
    exp_we_dir   = act && (m_e_taken != real_taken);
    exp_we_tgt   = act && real_taken && (!m_e_taken || (m_e_tgt != ALUResult_E));
    exp_mis      = act && ((m_e_taken != real_taken) ||
                           (real_taken && m_e_taken && (m_e_tgt != ALUResult_E)));
  endtask

  task automatic model_update();
    logic        old_d_taken;
    logic [31:0] old_d_tgt;
    old_d_taken = m_d_taken;
    old_d_tgt   = m_d_tgt;
    if (rst) begin
      m_d_taken = 0; m_d_tgt = 0; m_e_taken = 0; m_e_tgt = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (FlushD || exp_mis) begin m_d_taken = 0; m_d_tgt = 0; end
      else if (!StallD) begin m_d_taken = PrPCSrc_F; m_d_tgt = PrALUResult_F; end
      if (FlushE || exp_mis) begin m_e_taken = 0; m_e_tgt = 0; end
      else if (!StallE) begin m_e_taken = old_d_taken; m_e_tgt = old_d_tgt; end
      if (CntClr) begin
        m_bc = 0; m_mc = 0;
      end else begin
        if (!StallE && Branch_E) m_bc = (m_bc >= MAX) ? MAX : m_bc + 1;
        if (exp_mis)             m_mc = (m_mc >= MAX) ? MAX : m_mc + 1;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; PrPCSrc_F = 0; PrALUResult_F = 0;
    StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
    Branch_E = 0; PCSrc_E = 0; ALUResult_E = 0; PC_plus4_E = 0; CntClr = 0;
  endtask

  // Flush the pipe, then walk one prediction from F into E.
  task automatic load_pred(input logic taken, input logic [31:0] tgt);
    idle_inputs();
    FlushD = 1; FlushE = 1;
    tick();
    FlushD = 0; FlushE = 0;
    PrPCSrc_F = taken; PrALUResult_F = tgt;
    tick();
    PrPCSrc_F = 0; PrALUResult_F = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    tests_run++;
    if ({PrPCSrc_E, PrALUResult_E, Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult} !== '0 ||
        BranchCount !== 0 || MissCount !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset: pr=%b tgt=%h mis=%b redir=%h we=%b%b bc=%0d mc=%0d, required all 0",
               PrPCSrc_E, PrALUResult_E, Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult,
               BranchCount, MissCount);
    end
  endtask

  task automatic test_correct_taken();
    load_pred(1, 32'h100);
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h100; PC_plus4_E = 32'h44;
    @(negedge clk);
    tests_run++;
    if (PrPCSrc_E !== 1 || PrALUResult_E !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL latency: got %b/%h, required 1/00000100", PrPCSrc_E, PrALUResult_E);
    end
    tests_run++;
    if (Mispredict_E !== 0 || WE_PrPCSrc !== 0 || WE_PrALUResult !== 0) begin
      tests_failed++;
      $display("[TB] FAIL correct_taken: mis/we=%b%b%b, required 000", Mispredict_E, WE_PrPCSrc, WE_PrALUResult);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (BranchCount !== 1 || MissCount !== 0) begin
      tests_failed++;
      $display("[TB] FAIL correct_taken_counts: bc=%0d mc=%0d, required 1/0", BranchCount, MissCount);
    end
  endtask

  task automatic test_dir_miss();
    idle_inputs();
    FlushD = 1; FlushE = 1;
    tick();
    FlushD = 0; FlushE = 0;
    tick();
    PrPCSrc_F = 1; PrALUResult_F = 32'h500;
    tick();
    PrPCSrc_F = 0; PrALUResult_F = 0; StallD = 1;
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h200; PC_plus4_E = 32'h44;
    @(negedge clk);
    tests_run++;
    if (Mispredict_E !== 1 || PC_Redirect !== 32'h200 || WE_PrPCSrc !== 1 || WE_PrALUResult !== 1) begin
      tests_failed++;
      $display("[TB] FAIL dir_miss: mis=%b redir=%h we=%b%b, required 1/00000200/11",
               Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (PrPCSrc_E !== 0 || Mispredict_E !== 0) begin
      tests_failed++;
      $display("[TB] FAIL dir_miss_flushE: pr=%b mis=%b, required 0/0", PrPCSrc_E, Mispredict_E);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (PrPCSrc_E !== 0 || PrALUResult_E !== 0) begin
      tests_failed++;
      $display("[TB] FAIL dir_miss_flushD: pr=%b tgt=%h, required 0/00000000", PrPCSrc_E, PrALUResult_E);
    end
  endtask

  task automatic test_tgt_miss();
    int mc0;
    load_pred(1, 32'h100);
    mc0 = MissCount;
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h180; PC_plus4_E = 32'h44;
    @(negedge clk);
    tests_run++;
    if (Mispredict_E !== 1 || PC_Redirect !== 32'h180 || WE_PrPCSrc !== 0 || WE_PrALUResult !== 1) begin
      tests_failed++;
      $display("[TB] FAIL tgt_miss: mis=%b redir=%h we=%b%b, required 1/00000180/01",
               Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (int'(MissCount) !== mc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL tgt_miss_count: mc=%0d, required %0d", MissCount, mc0 + 1);
    end
  endtask

  task automatic test_not_taken_miss();
    load_pred(1, 32'h100);
    Branch_E = 1; PCSrc_E = 0; ALUResult_E = 32'h100; PC_plus4_E = 32'h48;
    @(negedge clk);
    tests_run++;
    if (Mispredict_E !== 1 || PC_Redirect !== 32'h48 || WE_PrPCSrc !== 1 || WE_PrALUResult !== 0) begin
      tests_failed++;
      $display("[TB] FAIL nt_miss: mis=%b redir=%h we=%b%b, required 1/00000048/10",
               Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_alias();
    int bc0, mc0;
    load_pred(1, 32'h80);
    bc0 = BranchCount; mc0 = MissCount;
    Branch_E = 0; PCSrc_E = 1; ALUResult_E = 32'h80; PC_plus4_E = 32'h30;
    @(negedge clk);
    tests_run++;
    if (Mispredict_E !== 1 || PC_Redirect !== 32'h30 || WE_PrPCSrc !== 1 || WE_PrALUResult !== 0) begin
      tests_failed++;
      $display("[TB] FAIL alias: mis=%b redir=%h we=%b%b, required 1/00000030/10",
               Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (int'(BranchCount) !== bc0 || int'(MissCount) !== mc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL alias_counts: bc=%0d mc=%0d, required %0d/%0d", BranchCount, MissCount, bc0, mc0 + 1);
    end
  endtask

  task automatic test_stall_d();
    idle_inputs();
    FlushD = 1; FlushE = 1;
    tick();
    FlushD = 0; FlushE = 0;
    PrPCSrc_F = 1; PrALUResult_F = 32'h300;
    tick();
    StallD = 1; StallE = 1; PrPCSrc_F = 0; PrALUResult_F = 32'h999;
    tick();
    tick();
    StallD = 0; StallE = 0; PrALUResult_F = 0;
    tick();
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h300;
    @(negedge clk);
    tests_run++;
    if (PrPCSrc_E !== 1 || PrALUResult_E !== 32'h300 || Mispredict_E !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_d: pr=%b tgt=%h mis=%b, required 1/00000300/0", PrPCSrc_E, PrALUResult_E, Mispredict_E);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall_e();
    int mc0, pulses;
    load_pred(1, 32'h100);
    mc0 = MissCount;
    pulses = 0;
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h180; StallE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (Mispredict_E !== 0 || WE_PrALUResult !== 0) begin
        tests_failed++;
        $display("[TB] FAIL stall_e_hold%0d: mis=%b we=%b, required 0/0", i, Mispredict_E, WE_PrALUResult);
      end
      tick();
    end
    StallE = 0;
    @(negedge clk);
    if (Mispredict_E === 1) pulses++;
    tick();
    Branch_E = 0; PCSrc_E = 0;
    @(negedge clk);
    if (Mispredict_E === 1) pulses++;
    tick();
    tests_run++;
    if (pulses !== 1 || int'(MissCount) !== mc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_e_once: pulses=%0d mc=%0d, required 1/%0d", pulses, MissCount, mc0 + 1);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    CntClr = 1;
    tick();
    for (int i = 0; i < 20; i++) begin
      load_pred(1, 32'h40);
      Branch_E = 0; PC_plus4_E = 32'h30;
      tick();
    end
    idle_inputs();
    tests_run++;
    if (MissCount !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL saturation: mc=%0d, required 15", MissCount);
    end
    load_pred(1, 32'h40);
    CntClr = 1;
    tick();
    idle_inputs();
    tests_run++;
    if (MissCount !== 0 || BranchCount !== 0) begin
      tests_failed++;
      $display("[TB] FAIL cntclr_priority: bc=%0d mc=%0d, required 0/0", BranchCount, MissCount);
    end
  endtask

  task automatic test_reset_midstream();
    load_pred(1, 32'h100);
    StallE = 1; StallD = 1; FlushD = 1; Branch_E = 1;
    PrPCSrc_F = 1; PrALUResult_F = 32'h700;
    rst = 1;
    tick();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (PrPCSrc_E !== 0 || PrALUResult_E !== 0 || BranchCount !== 0 || MissCount !== 0 || Mispredict_E !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: pr=%b tgt=%h bc=%0d mc=%0d mis=%b, required all 0",
               PrPCSrc_E, PrALUResult_E, BranchCount, MissCount, Mispredict_E);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgts [4];
    tgts[0] = 32'h100; tgts[1] = 32'h104; tgts[2] = 32'h200; tgts[3] = 32'h3fc;
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      CntClr        = ($urandom_range(0, 39) == 0);
      StallD        = ($urandom_range(0, 4) == 0);
      StallE        = ($urandom_range(0, 4) == 0);
      FlushD        = ($urandom_range(0, 9) == 0);
      FlushE        = ($urandom_range(0, 9) == 0);
      PrPCSrc_F     = 1'($urandom_range(0, 1));
      PrALUResult_F = tgts[$urandom_range(0, 3)];
      Branch_E      = ($urandom_range(0, 3) != 0);
      PCSrc_E       = 1'($urandom_range(0, 1));
      ALUResult_E   = tgts[$urandom_range(0, 3)];
      PC_plus4_E    = $urandom & 32'hffff_fffc;
      @(negedge clk);
      model_eval();
      tests_run++;
      if (Mispredict_E !== exp_mis || PC_Redirect !== exp_redirect ||
          WE_PrPCSrc !== exp_we_dir || WE_PrALUResult !== exp_we_tgt) begin
        tests_failed++;
        $display("[TB] FAIL rand_resolve[%0d]: mis=%b redir=%h we=%b%b, required %b/%h/%b%b", i,
                 Mispredict_E, PC_Redirect, WE_PrPCSrc, WE_PrALUResult,
                 exp_mis, exp_redirect, exp_we_dir, exp_we_tgt);
      end
      tests_run++;
      if (PrPCSrc_E !== m_e_taken || PrALUResult_E !== m_e_tgt ||
          int'(BranchCount) !== m_bc || int'(MissCount) !== m_mc) begin
        tests_failed++;
        $display("[TB] FAIL rand_state[%0d]: pr=%b tgt=%h bc=%0d mc=%0d, required %b/%h/%0d/%0d", i,
                 PrPCSrc_E, PrALUResult_E, BranchCount, MissCount, m_e_taken, m_e_tgt, m_bc, m_mc);
      end
      tick();
    end
    idle_inputs();
  endtask

  // Directed scenarios first, then the randomized sweep.
  initial begin
    m_d_taken = 0; m_d_tgt = 0; m_e_taken = 0; m_e_tgt = 0; m_bc = 0; m_mc = 0;
    idle_inputs();
    test_reset();
    test_correct_taken();
    test_dir_miss();
    test_tgt_miss();
    test_not_taken_miss();
    test_alias();
    test_stall_d();
    test_stall_e();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
